piano_synth: RTL and testbench

Parametrised monophonic tone generator. It replaces the fixed 8-switch piano with a configurable key count, a per-key half-period table, per-key debouncing, two note-priority modes, octave shift and a release sustain. It sits between the board switches and the speaker pin. It drives a square wave on FREQ and shows the sounding note on the LEDs.

---
 rtl/piano_synth.sv | 199 +++++++++++++++++++
 tb/tb_piano_synth.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piano_synth.sv
`timescale 1ns/1ps
// piano_synth: monophonic square-wave tone generator driven by debounced key
// switches, with two note-priority modes, octave shift and release sustain.
module piano_synth #(
   parameter int NUM_KEYS = 8,
   parameter int CNT_W = 18,
   parameter logic [NUM_KEYS*CNT_W-1:0] HALF_PERIODS = {
      18'd191110, 18'd170265, 18'd151685, 18'd143172,
      18'd127551, 18'd113636, 18'd101239, 18'd95556},
   parameter int DEB_CYC = 1000000,
   parameter int SUS_CYC = 25000000
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic [NUM_KEYS-1:0]           sw,
   input  logic                          mode,
   input  logic [1:0]                    oct,
   output logic                          FREQ,
   output logic [NUM_KEYS-1:0]           Led,
   output logic [$clog2(NUM_KEYS)-1:0]   NOTE,
   output logic                          ACTIVE
);

   localparam int NOTE_W = $clog2(NUM_KEYS);
   localparam int HALF_W = CNT_W + 1;
   localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
   localparam int SUS_W = (SUS_CYC > 1) ? $clog2(SUS_CYC) : 1;
   localparam logic [SUS_W-1:0] SUS_LAST = SUS_W'((SUS_CYC > 0) ? SUS_CYC - 1 : 0);

   typedef enum logic [1:0] {IDLE, PLAY, SUSTAIN} state_t;

   state_t              state;
   logic [NUM_KEYS-1:0] sync1, sync2, deb, deb_d, press;
   logic [NOTE_W-1:0]   last_q, note_q, sel, low_held, low_press;
   logic [NUM_KEYS-1:0] sel_led;
   logic                any_key;
   logic [CNT_W-1:0]    tbl;
   logic [HALF_W-1:0]   half, tone_cnt, run_cnt;
   logic                tone_wrap, run_freq;
   logic [SUS_W-1:0]    sus_cnt;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw;
         sync2 <= sync1;
      end
   end

   // The counter only runs while the synchronised key disagrees with its
   // debounced value, so any bounce back restarts the stability window.
   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
      logic             deb_r;
      logic [DEB_W-1:0] deb_cnt;

      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N) begin
            deb_r   <= 1'b0;
            deb_cnt <= '0;
         end else if (sync2[k] == deb_r) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_r   <= sync2[k];
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end

      assign deb[k] = deb_r;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         deb_d  <= '0;
         last_q <= '0;
      end else begin
         deb_d <= deb;
         if (|press) last_q <= low_press;
      end
   end

   // Last-pressed priority falls back to the lowest held key once the
   // remembered key is no longer held.
   always_comb begin
      press     = deb & ~deb_d;
      any_key   = |deb;
      low_held  = '0;
      low_press = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (deb[i])   low_held  = NOTE_W'(i);
         if (press[i]) low_press = NOTE_W'(i);
      end
      sel = low_held;
      if (mode) begin
         if (|press)           sel = low_press;
         else if (deb[last_q]) sel = last_q;
      end
      sel_led = NUM_KEYS'(1) << sel;
   end

   always_comb begin
      tbl = HALF_PERIODS[int'(note_q) * CNT_W +: CNT_W];
      case (oct)
         2'd0:    half = {1'b0, tbl};
         2'd1:    half = {2'b0, tbl[CNT_W-1:1]};
         2'd2:    half = {3'b0, tbl[CNT_W-1:2]};
         default: half = {tbl, 1'b0};
      endcase
      if (half == '0) half = HALF_W'(1);
      tone_wrap = tone_cnt >= half - 1'b1;
      run_cnt   = tone_wrap ? '0 : tone_cnt + 1'b1;
      run_freq  = tone_wrap ? ~FREQ : FREQ;
   end

   // A note change clears the tone counter but keeps FREQ at its level, so
   // the new pitch starts a fresh half-period without a short pulse.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         note_q   <= '0;
         tone_cnt <= '0;
         sus_cnt  <= '0;
         FREQ     <= 1'b0;
         Led      <= '0;
         NOTE     <= '0;
         ACTIVE   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tone_cnt <= '0;
               FREQ     <= 1'b0;
               if (any_key) begin
                  state  <= PLAY;
                  note_q <= sel;
                  Led    <= sel_led;
                  NOTE   <= sel;
                  ACTIVE <= 1'b1;
               end
            end
            PLAY: begin
               if (!any_key) begin
                  if (SUS_CYC == 0) begin
                     state    <= IDLE;
                     tone_cnt <= '0;
                     FREQ     <= 1'b0;
                     Led      <= '0;
                     NOTE     <= '0;
                     ACTIVE   <= 1'b0;
                  end else begin
                     state    <= SUSTAIN;
                     sus_cnt  <= '0;
                     tone_cnt <= run_cnt;
                     FREQ     <= run_freq;
                  end
               end else if (sel != note_q) begin
                  note_q   <= sel;
                  Led      <= sel_led;
                  NOTE     <= sel;
                  tone_cnt <= '0;
               end else begin
                  tone_cnt <= run_cnt;
                  FREQ     <= run_freq;
               end
            end
            SUSTAIN: begin
               if (any_key) begin
                  state <= PLAY;
                  if (sel != note_q) begin
                     note_q   <= sel;
                     Led      <= sel_led;
                     NOTE     <= sel;
                     tone_cnt <= '0;
                  end else begin
                     tone_cnt <= run_cnt;
                     FREQ     <= run_freq;
                  end
               end else if (sus_cnt == SUS_LAST) begin
                  state    <= IDLE;
                  tone_cnt <= '0;
                  FREQ     <= 1'b0;
                  Led      <= '0;
                  NOTE     <= '0;
                  ACTIVE   <= 1'b0;
               end else begin
                  sus_cnt  <= sus_cnt + 1'b1;
                  tone_cnt <= run_cnt;
                  FREQ     <= run_freq;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piano_synth.sv
`timescale 1ns/1ps
// tb_piano_synth: directed and randomized key/mode/octave stimulus for
// piano_synth, checked every cycle against a behavioural model via a scoreboard.
module tb_piano_synth;

   localparam int KEYS = 8;
   localparam int DEB = 4;
   localparam int SUS = 20;
   localparam logic [63:0] HP = {8'd36, 8'd32, 8'd28, 8'd24, 8'd20, 8'd16, 8'd12, 8'd8};

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic [7:0] sw = '0;
   logic       mode = 1'b0;
   logic [1:0] oct = '0;
   logic       FREQ;
   logic [7:0] Led;
   logic [2:0] NOTE;
   logic       ACTIVE;

   piano_synth #(
      .NUM_KEYS(KEYS), .CNT_W(8), .HALF_PERIODS(HP), .DEB_CYC(DEB), .SUS_CYC(SUS)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .sw(sw), .mode(mode), .oct(oct),
      .FREQ(FREQ), .Led(Led), .NOTE(NOTE), .ACTIVE(ACTIVE)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       freq;
      logic [7:0] led;
      logic [2:0] note;
      logic       active;
   } obs_t;

   obs_t sb [$];
   int   checks = 0;
   int   passes = 0;

   logic [7:0] want_sw = '0;
   logic       want_mode = 1'b0;
   logic [1:0] want_oct = '0;

   logic [7:0] m_s1, m_s2, m_deb, m_prev;
   int         m_streak [KEYS];
   int         m_last, m_note, m_phase, m_sus;
   bit         m_on, m_freq;

   function automatic int lowest(logic [7:0] v);
      for (int i = 0; i < KEYS; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic int half_of(int k, logic [1:0] o);
      int h;
      h = 4 * (k + 2);
      case (o)
         2'd1:    h = h / 2;
         2'd2:    h = h / 4;
         2'd3:    h = h * 2;
         default: h = h;
      endcase
      return (h < 1) ? 1 : h;
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0;
      for (int k = 0; k < KEYS; k++) m_streak[k] = 0;
      m_last = 0; m_note = 0; m_phase = 0; m_sus = -1;
      m_on = 1'b0; m_freq = 1'b0;
   endtask

   task automatic model_tone(logic [1:0] o);
      if (m_phase + 1 >= half_of(m_note, o)) begin
         m_phase = 0;
         m_freq  = !m_freq;
      end else begin
         m_phase++;
      end
   endtask

   // One rising clock edge of the expected behaviour, using the inputs sampled there.
   task automatic model_step(logic [7:0] s, logic m, logic [1:0] o);
      logic [7:0] press;
      int         sel;
      obs_t       e;
      press = m_deb & ~m_prev;
      sel = lowest(m_deb);
      if (m) begin
         if (press != 0)          sel = lowest(press);
         else if (m_deb[m_last])  sel = m_last;
      end
      if (!m_on) begin
         if (m_deb != 0) begin
            m_on = 1'b1; m_sus = -1; m_note = sel; m_phase = 0;
         end
      end else if (m_deb != 0) begin
         m_sus = -1;
         if (sel != m_note) begin
            m_note = sel; m_phase = 0;
         end else model_tone(o);
      end else if (m_sus < 0) begin
         m_sus = 0;
         model_tone(o);
      end else if (m_sus == SUS - 1) begin
         m_on = 1'b0; m_freq = 1'b0; m_phase = 0; m_sus = -1;
      end else begin
         m_sus++;
         model_tone(o);
      end
      if (press != 0) m_last = lowest(press);
      m_prev = m_deb;
      for (int k = 0; k < KEYS; k++) begin
         if (m_s2[k] != m_deb[k]) begin
            m_streak[k]++;
            if (m_streak[k] == DEB) begin
               m_deb[k] = m_s2[k];
               m_streak[k] = 0;
            end
         end else m_streak[k] = 0;
      end
      m_s2 = m_s1;
      m_s1 = s;
      e.freq   = m_freq;
      e.led    = m_on ? 8'(1 << m_note) : 8'h00;
      e.note   = m_on ? 3'(m_note) : 3'd0;
      e.active = m_on;
      sb.push_back(e);
   endtask

   task automatic applyStimulus();
      @(negedge CLK);
      sw   = want_sw;
      mode = want_mode;
      oct  = want_oct;
      model_step(want_sw, want_mode, want_oct);
   endtask

   task automatic checkOutput(string name, int actual, int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic measure_period(output int per);
      int   t;
      int   first;
      logic prev;
      t = 0; first = -1; per = -1; prev = FREQ;
      while (t < 600 && per < 0) begin
         applyStimulus();
         t++;
         if (FREQ && !prev) begin
            if (first < 0) first = t;
            else per = t - first;
         end
         prev = FREQ;
      end
   endtask

   initial begin
      obs_t exp_o, got;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() > 0) begin
            exp_o = sb.pop_front();
            got = {FREQ, Led, NOTE, ACTIVE};
            checks++;
            if (got === exp_o) passes++;
            else $display("[TB] FAIL scoreboard @%0t: got freq=%0b led=%h note=%0d active=%0b, expected freq=%0b led=%h note=%0d active=%0b",
                          $time, got.freq, got.led, got.note, got.active,
                          exp_o.freq, exp_o.led, exp_o.note, exp_o.active);
         end
      end
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n, per, low_cnt;
      int exp_per [4] = '{72, 36, 18, 144};

      model_reset();
      sw = 8'hFF;
      repeat (9) begin
         @(negedge CLK);
         checkOutput("reset_hold", int'({FREQ, Led, NOTE, ACTIVE}), 0);
      end
      #5 sw = '0;
      #5 RESET_N = 1'b1;

      want_sw = 8'h20;
      applyStimulus();
      repeat (6) applyStimulus();
      checkOutput("latency_before", int'(Led), 0);
      applyStimulus();
      checkOutput("single_led", int'(Led), 'h20);
      checkOutput("single_note", int'(NOTE), 5);
      checkOutput("single_active", int'(ACTIVE), 1);
      measure_period(per);
      checkOutput("period_key5", per, 56);
      want_sw = '0;
      applyStimulus();
      n = 0;
      while (ACTIVE && n < 100) begin
         applyStimulus();
         n++;
      end
      checkOutput("sustain_len", n, 2 + DEB + 1 + SUS);
      checkOutput("sustain_freq_off", int'(FREQ), 0);

      want_sw = 8'h40;
      repeat (10) applyStimulus();
      want_sw = 8'h44;
      repeat (8) applyStimulus();
      checkOutput("mode0_high", int'(Led), 'h04);
      measure_period(per);
      checkOutput("period_key2", per, 32);
      want_sw = 8'h40;
      repeat (8) applyStimulus();
      checkOutput("mode0_fallback", int'(Led), 'h40);

      want_sw = '0;
      repeat (40) applyStimulus();
      want_mode = 1'b1;
      want_sw = 8'h04;
      repeat (10) applyStimulus();
      want_sw = 8'h44;
      repeat (8) applyStimulus();
      checkOutput("mode1_last", int'(Led), 'h40);
      want_sw = 8'h04;
      repeat (8) applyStimulus();
      checkOutput("mode1_fallback", int'(Led), 'h04);

      want_sw = '0;
      want_mode = 1'b0;
      repeat (40) applyStimulus();
      want_sw = 8'h80;
      repeat (10) applyStimulus();
      for (int o = 0; o < 4; o++) begin
         want_oct = 2'(o);
         measure_period(per);
         checkOutput($sformatf("period_oct%0d", o), per, exp_per[o]);
      end
      repeat (30) applyStimulus();
      checkOutput("oct_pre_change", int'(FREQ), 1);
      want_oct = 2'd2;
      repeat (2) applyStimulus();
      checkOutput("oct_mid_toggle", int'(FREQ), 0);
      repeat (20) applyStimulus();

      @(negedge CLK);
      #2 RESET_N = 1'b0;
      sb.delete();
      #1 checkOutput("async_reset", int'({FREQ, Led, NOTE, ACTIVE}), 0);
      repeat (3) @(negedge CLK);
      checkOutput("reset_no_toggle", int'(FREQ), 0);
      sw = '0; want_sw = '0; want_oct = '0; oct = '0;
      model_reset();
      #2 RESET_N = 1'b1;

      want_sw = 8'h01;
      repeat (3) applyStimulus();
      want_sw = '0;
      repeat (10) applyStimulus();
      checkOutput("deb_pulse", int'(ACTIVE), 0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         want_sw[0] = ~want_sw[0];
         repeat (2) begin
            applyStimulus();
            if (ACTIVE) n++;
         end
      end
      repeat (6) applyStimulus();
      checkOutput("deb_chatter", n + int'(ACTIVE), 0);

      want_sw = 8'h01;
      repeat (10) applyStimulus();
      want_sw = '0;
      repeat (15) applyStimulus();
      checkOutput("in_sustain", int'(ACTIVE), 1);
      want_sw = 8'h01;
      low_cnt = 0;
      repeat (30) begin
         applyStimulus();
         if (!ACTIVE) low_cnt++;
      end
      checkOutput("sustain_repress", low_cnt, 0);

      for (int i = 0; i < 3000; i++) begin
         int k;
         k = $urandom_range(0, KEYS - 1);
         if ($urandom_range(0, 9) == 0)   want_sw[k] = ~want_sw[k];
         if ($urandom_range(0, 149) == 0) want_mode = ~want_mode;
         if ($urandom_range(0, 99) == 0)  want_oct = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 399) == 0) want_sw = '0;
         applyStimulus();
      end

      want_sw = '0;
      repeat (2) applyStimulus();
      @(posedge CLK);
      #2;
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
